// File: rtl/dac_data_out.sv
// Avalon-MM DAC output port: CPU-filled sample FIFO drained at a programmable
// tick rate onto out_port, with readable status and sticky underrun/overflow.
module dac_data_out #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_BITS  = 4,
  parameter int DIV_RESET  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_strobe
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_BITS-1:0]  wr_ptr_q, rd_ptr_q;
  logic [ADDR_BITS:0]    level_q, level_d;
  logic [15:0]           div_q, div_d, cnt_q, cnt_d;
  logic                  en_q, en_d;
  logic                  underrun_q, underrun_d, overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] port_q, port_d;
  logic                  strobe_q;
  logic [31:0]           rdata_q, rdata_d;

  logic wr, push, push_ok, pop, tick, full, empty, cfg_wr, clr_wr;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:17];

  always_comb begin
    wr      = chipselect & ~write_n;
    push    = wr && (address == 2'd0);
    cfg_wr  = wr && (address == 2'd1);
    clr_wr  = wr && (address == 2'd3);
    full    = (level_q == (ADDR_BITS+1)'(FIFO_DEPTH));
    empty   = (level_q == '0);
    tick    = en_q && (cnt_q == '0);
    pop     = tick && !empty;
    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    push_ok = push && (!full || pop);
    level_d = level_q + (ADDR_BITS+1)'(push_ok) - (ADDR_BITS+1)'(pop);

    div_d = div_q;
    en_d  = en_q;
    if (cfg_wr) begin
      div_d = writedata[15:0];
      en_d  = writedata[16];
    end

    if (cfg_wr)              cnt_d = writedata[15:0];
    else if (!en_q || tick)  cnt_d = div_q;
    else                     cnt_d = cnt_q - 16'd1;

    underrun_d = underrun_q | (tick & empty);
    overflow_d = overflow_q | (push & full & ~pop);
    // Clear beats a simultaneous set.
    if (clr_wr) begin
      underrun_d = 1'b0;
      overflow_d = 1'b0;
    end

    port_d = pop ? mem_q[rd_ptr_q] : port_q;

    rdata_d = '0;
    case (address)
      2'd0: rdata_d[DATA_WIDTH-1:0] = port_q;
      2'd1: rdata_d[16:0] = {en_q, div_q};
      2'd2: begin
        rdata_d[8 +: ADDR_BITS+1] = level_q;
        rdata_d[1] = full;
        rdata_d[0] = empty;
      end
      default: rdata_d[1:0] = {overflow_q, underrun_q};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      div_q      <= 16'(DIV_RESET);
      cnt_q      <= 16'(DIV_RESET);
      en_q       <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      port_q     <= '0;
      strobe_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q    <= level_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      port_q     <= port_d;
      strobe_q   <= pop;
      rdata_q    <= rdata_d;
    end
  end

  // Sample storage carries no reset; validity is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= writedata[DATA_WIDTH-1:0];
  end

  assign readdata   = rdata_q;
  assign out_port   = port_q;
  assign out_strobe = strobe_q;

endmodule

// File: tb/tb_dac_data_out.sv
// Bench for dac_data_out: table vectors, directed corner sequences and random
// traffic, all checked against a queue-based behavioural model.
module tb_dac_data_out;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        out_strobe;

  dac_data_out #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .ADDR_BITS(4), .DIV_RESET(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .out_strobe(out_strobe)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Behavioural model state
  logic [7:0] q[$];
  bit         m_en, m_uf, m_of;
  int         m_div, m_w;
  logic [7:0] m_port;

  typedef struct {
    logic [1:0]  addr;
    bit          wr;
    logic [31:0] wd;
    bit          chk;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  function automatic void mdl_reset();
    q.delete();
    m_en = 0; m_div = 0; m_w = 0; m_uf = 0; m_of = 0; m_port = '0;
  endfunction

  function automatic void add(logic [1:0] a, bit w, logic [31:0] d, bit c, logic [31:0] e);
    vec_t v;
    v.addr = a; v.wr = w; v.wd = d; v.chk = c; v.exp = e;
    tbl.push_back(v);
  endfunction

  // One clock: predict from the rules, clock, then compare #1 after the edge.
  task automatic step();
    logic [31:0] rd_e;
    bit tk, pop, push, wr, full, empty, s_e;
    int lvl;
    wr    = chipselect && !write_n;
    lvl   = q.size();
    full  = (lvl == DEPTH);
    empty = (lvl == 0);
    case (address)
      2'd0:    rd_e = {24'd0, m_port};
      2'd1:    rd_e = {15'd0, m_en, 16'(m_div)};
      2'd2:    rd_e = (32'(lvl) << 8) | {30'd0, full, empty};
      default: rd_e = {30'd0, m_of, m_uf};
    endcase
    tk   = m_en && (cyc > m_w) && (((cyc - m_w) % (m_div + 1)) == 0);
    pop  = tk && !empty;
    push = wr && (address == 2'd0);
    s_e  = pop;
    if (tk && empty) m_uf = 1;
    if (push && full && !pop) m_of = 1;
    if (pop) m_port = q.pop_front();
    if (push && (!full || pop)) q.push_back(writedata[7:0]);
    if (wr && address == 2'd3) begin m_uf = 0; m_of = 0; end
    if (wr && address == 2'd1) begin
      m_en = writedata[16]; m_div = int'(writedata[15:0]); m_w = cyc;
    end
    @(posedge clk); #1;
    chk("readdata", readdata, rd_e);
    chk("out_port", 32'(out_port), 32'(m_port));
    chk("out_strobe", 32'(out_strobe), 32'(s_e));
    cyc++;
  endtask

  task automatic bus(bit w, logic [1:0] a, logic [31:0] d);
    chipselect = w; write_n = !w; address = a; writedata = d;
    step();
  endtask

  task automatic do_reset();
    chipselect = 0; write_n = 1; address = 0; writedata = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    cyc += 2;
    mdl_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sc[$];
    logic [7:0] sv[$];
    int nstr;
    int r;

    do_reset();

    // Table: reset values, overflow, drain at divider 0
    for (int i = 0; i < 4; i++) add(2'(i), 0, 0, 1, (i == 2) ? 32'h1 : 32'h0);
    for (int i = 0; i <= 16; i++) add(2'd0, 1, 32'(i), 0, 0);
    add(2'd2, 0, 0, 1, 32'h1002);
    add(2'd3, 0, 0, 1, 32'h2);
    add(2'd3, 1, 0, 1, 32'h2);
    add(2'd3, 0, 0, 1, 32'h0);
    add(2'd1, 1, 32'h10000, 0, 0);
    for (int i = 0; i < 18; i++) add(2'd0, 0, 0, 0, 0);
    add(2'd0, 0, 0, 1, 32'h0F);
    add(2'd3, 0, 0, 1, 32'h1);
    add(2'd2, 0, 0, 1, 32'h1);
    add(2'd1, 0, 0, 1, 32'h10000);
    foreach (tbl[i]) begin
      bus(tbl[i].wr, tbl[i].addr, tbl[i].wd);
      if (tbl[i].chk) chk($sformatf("tbl[%0d]", i), readdata, tbl[i].exp);
    end

    // Sample rate: divider 4
    do_reset();
    bus(1, 2'd0, 32'h11);
    bus(1, 2'd0, 32'h22);
    bus(1, 2'd0, 32'h33);
    bus(1, 2'd1, 32'h10004);
    for (int i = 0; i < 30; i++) begin
      bus(0, 2'd3, 0);
      if (out_strobe) begin sc.push_back(cyc); sv.push_back(out_port); end
    end
    chk("rate_nstrobes", 32'(sc.size()), 32'd3);
    if (sc.size() == 3) begin
      chk("rate_gap1", 32'(sc[1] - sc[0]), 32'd5);
      chk("rate_gap2", 32'(sc[2] - sc[1]), 32'd5);
      chk("rate_val0", 32'(sv[0]), 32'h11);
      chk("rate_val1", 32'(sv[1]), 32'h22);
      chk("rate_val2", 32'(sv[2]), 32'h33);
    end
    chk("rate_underrun", readdata, 32'h1);
    chk("rate_hold", 32'(out_port), 32'h33);

    // Boundary: full FIFO, divider 0, push on a tick
    do_reset();
    for (int i = 0; i < 16; i++) bus(1, 2'd0, 32'(8'h40 + i));
    bus(1, 2'd1, 32'h10000);
    bus(1, 2'd0, 32'hAA);
    bus(0, 2'd2, 0);
    chk("full_push_level", readdata, 32'h1002);
    bus(0, 2'd3, 0);
    chk("full_push_noovf", readdata, 32'h0);
    for (int i = 0; i < 20; i++) bus(0, 2'd0, 0);
    // Flag clear racing an underrun tick, then a fresh empty tick
    bus(1, 2'd3, 0);
    bus(0, 2'd3, 0);
    chk("clr_wins", readdata, 32'h0);
    bus(0, 2'd3, 0);
    chk("clr_reset", readdata, 32'h1);
    // Push at empty on a tick: accepted, underrun
    bus(1, 2'd3, 0);
    bus(1, 2'd0, 32'h5A);
    bus(0, 2'd2, 0);
    chk("empty_push_level", readdata, 32'h100);
    bus(0, 2'd3, 0);
    chk("empty_push_ur", readdata, 32'h1);
    bus(0, 2'd0, 0);
    chk("empty_push_out", readdata, 32'h5A);

    // Asynchronous reset mid-stream with level 5
    do_reset();
    for (int i = 1; i <= 6; i++) bus(1, 2'd0, 32'(i));
    bus(1, 2'd1, 32'h1000A);
    for (int i = 0; i < 12; i++) bus(0, 2'd2, 0);
    chk("pre_rst_level", readdata, 32'h500);
    chk("pre_rst_port", 32'(out_port), 32'h1);
    #2 reset_n = 0;
    #1;
    chk("async_port", 32'(out_port), 32'h0);
    chk("async_rdata", readdata, 32'h0);
    chk("async_strobe", 32'(out_strobe), 32'h0);
    @(posedge clk); #1;
    reset_n = 1;
    cyc++;
    mdl_reset();
    nstr = 0;
    for (int i = 0; i < 30; i++) begin
      bus(0, 2'd2, 0);
      if (out_strobe) nstr++;
    end
    chk("post_rst_nostrobe", 32'(nstr), 32'd0);
    chk("post_rst_level", readdata, 32'h1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40)      bus(1, 2'd0, $urandom());
      else if (r < 45) bus(1, 2'd1, {15'd0, 1'($urandom_range(0, 4) != 0), 16'($urandom_range(0, 5))});
      else if (r < 50) bus(1, 2'd3, $urandom());
      else if (r < 53) bus(1, 2'd2, $urandom());
      else begin
        chipselect = 1'($urandom_range(0, 1));
        write_n    = (chipselect) ? 1'b1 : 1'($urandom_range(0, 1));
        address    = 2'($urandom_range(0, 3));
        writedata  = $urandom();
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
